fma_dot_sequencer: RTL

Sequential initiator for the combinational `fpfma` datapath. It accepts a start command, streams a vector of operand pairs over a valid/ready port, and issues one fused multiply-add per pair, feeding each result back as the addend of the next. It returns the final dot-product accumulator on a valid/ready result port. It sits between the operand memory/stream logic and an `fpfma` instance, and drives that instance's A, B, C and rnd inputs from registers.

---
 rtl/fma_dot_sequencer_if.sv | 33 +++
 rtl/fma_dot_sequencer.sv | 90 +++++++++
 2 files changed

// File: rtl/fma_dot_sequencer_if.sv
// fma_dot_sequencer_if: command, operand, fpfma and result signals of the dot-product sequencer
interface fma_dot_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int LEN_WIDTH = 8
);
  logic start;
  logic [LEN_WIDTH-1:0] len;
  logic [WIDTH-1:0] init;
  logic [1:0] rnd_mode;
  logic busy;
  logic op_valid;
  logic op_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] fma_a;
  logic [WIDTH-1:0] fma_b;
  logic [WIDTH-1:0] fma_c;
  logic [1:0] fma_rnd;
  logic [WIDTH-1:0] fma_result;
  logic res_valid;
  logic res_ready;
  logic [WIDTH-1:0] res_data;
  logic [LEN_WIDTH-1:0] res_count;
  logic err;
  modport master (
    output start, len, init, rnd_mode, op_valid, op_a, op_b, fma_result, res_ready,
    input busy, op_ready, fma_a, fma_b, fma_c, fma_rnd, res_valid, res_data, res_count, err
  );
  modport slave (
    input start, len, init, rnd_mode, op_valid, op_a, op_b, fma_result, res_ready,
    output busy, op_ready, fma_a, fma_b, fma_c, fma_rnd, res_valid, res_data, res_count, err
  );
endinterface

// File: rtl/fma_dot_sequencer.sv
// fma_dot_sequencer: streams operand pairs into an fpfma and accumulates a dot product; FMA_DOT_NAN_ABORT_EN enables NaN early abort
module fma_dot_sequencer #(
  parameter int WIDTH = 32,
  parameter int LEN_WIDTH = 8,
  parameter int FMA_LAT = 1
) (
  input logic clk,
  input logic rst,
  fma_dot_sequencer_if.slave bus
);
  localparam int LAT_W = FMA_LAT > 1 ? $clog2(FMA_LAT) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;
  state_t r_state;
  logic r_busy, r_op_ready, r_res_valid, r_err;
  logic [WIDTH-1:0] r_fma_a, r_fma_b, r_fma_c, r_acc;
  logic [1:0] r_fma_rnd;
  logic [LEN_WIDTH-1:0] r_len, r_cnt, w_cnt_inc;
  logic [LAT_W-1:0] r_lat_cnt;
  logic w_nan, w_stop;
`ifdef FMA_DOT_NAN_ABORT_EN
  localparam int EXP_W = WIDTH == 64 ? 11 : WIDTH == 16 ? 5 : 8;
  assign w_nan = &bus.fma_result[WIDTH-2 -: EXP_W] & |bus.fma_result[WIDTH-EXP_W-2:0];
`else
  assign w_nan = 1'b0;
`endif
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_stop = w_cnt_inc == r_len || w_nan;
  assign bus.busy = r_busy;
  assign bus.op_ready = r_op_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.err = r_err;
  assign bus.fma_a = r_fma_a;
  assign bus.fma_b = r_fma_b;
  assign bus.fma_c = r_fma_c;
  assign bus.fma_rnd = r_fma_rnd;
  assign bus.res_data = r_acc;
  assign bus.res_count = r_cnt;
  // Sequencer FSM with registered handshake, status and fpfma operand outputs
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_busy <= 1'b0;
      r_op_ready <= 1'b0;
      r_res_valid <= 1'b0;
      r_err <= 1'b0;
      r_fma_a <= '0;
      r_fma_b <= '0;
      r_fma_c <= '0;
      r_fma_rnd <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_lat_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_len <= bus.len;
          r_fma_rnd <= bus.rnd_mode;
          r_acc <= bus.init;
          r_cnt <= '0;
          r_err <= 1'b0;
          r_busy <= 1'b1;
          r_op_ready <= bus.len != '0;
          r_res_valid <= bus.len == '0;
          r_state <= bus.len == '0 ? DONE : FETCH;
        end
        FETCH: if (bus.op_valid) begin
          r_fma_a <= bus.op_a;
          r_fma_b <= bus.op_b;
          r_fma_c <= r_acc;
          r_lat_cnt <= LAT_W'(FMA_LAT - 1);
          r_op_ready <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: if (r_lat_cnt == '0) begin
          r_acc <= bus.fma_result;
          r_cnt <= w_cnt_inc;
          r_err <= r_err | w_nan;
          r_op_ready <= !w_stop;
          r_res_valid <= w_stop;
          r_state <= w_stop ? DONE : FETCH;
        end else r_lat_cnt <= r_lat_cnt - 1'b1;
        DONE: if (bus.res_ready) begin
          r_busy <= 1'b0;
          r_res_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
endmodule
